// File: rtl/axi_chan_multicut.sv
// axi_chan_multicut: AXI register slicing with an independent cut depth per
// channel. Each cut is a spill stage (FullThru=1) or a half stage (FullThru=0).
// idle_o is high when no beat is held anywhere inside the block.

package axi_chan_multicut_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_chan_t  r;
    logic     r_valid;
  } axi_resp_t;
endpackage

// One register stage: 2-slot spill register or 1-slot half register.
module axi_chan_multicut_stage #(
  parameter bit  FullThru = 1'b1,
  parameter type data_t   = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  data_t in_data_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output data_t out_data_o,
  output logic  empty_o
);
  if (FullThru) begin : g_full
    // Slot A drives the output; slot B only catches a beat while A is stalled.
    logic  a_full_q, b_full_q;
    data_t a_q, b_q;
    logic  push, pop;

    assign in_ready_o  = !b_full_q;
    assign push        = in_valid_i && !b_full_q;
    assign pop         = a_full_q && out_ready_i;
    assign out_valid_o = a_full_q;
    assign out_data_o  = a_q;
    assign empty_o     = !a_full_q;

    // Slot update; B can only hold a beat when A does, and no push lands while B is full.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
      end else if (pop && b_full_q) begin
        a_q      <= b_q;
        b_full_q <= 1'b0;
      end else if (push && (!a_full_q || pop)) begin
        a_q      <= in_data_i;
        a_full_q <= 1'b1;
      end else if (pop) begin
        a_full_q <= 1'b0;
      end else if (push) begin
        b_q      <= in_data_i;
        b_full_q <= 1'b1;
      end
    end
  end else begin : g_half
    // Single slot: accept only when empty, so push and pop never coincide.
    logic  full_q;
    data_t data_q;

    assign in_ready_o  = !full_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
    assign empty_o     = !full_q;

    // Fill when empty, drain when the far side takes the beat.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_q <= 1'b0;
      end else if (full_q) begin
        if (out_ready_i) full_q <= 1'b0;
      end else if (in_valid_i) begin
        full_q <= 1'b1;
        data_q <= in_data_i;
      end
    end
  end
endmodule

// A chain of Cuts stages for one channel; zero cuts degenerates to wires.
module axi_chan_multicut_chan #(
  parameter int unsigned Cuts     = 1,
  parameter bit          FullThru = 1'b1,
  parameter type         data_t   = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  data_t in_data_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output data_t out_data_o,
  output logic  empty_o
);
  if (Cuts == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign out_valid_o    = in_valid_i;
    assign out_data_o     = in_data_i;
    assign in_ready_o     = out_ready_i;
    assign empty_o        = 1'b1;
  end else begin : g_cut
    logic [Cuts:0]   vld, rdy;
    data_t           dat [Cuts+1];
    logic [Cuts-1:0] emp;

    assign vld[0]      = in_valid_i;
    assign dat[0]      = in_data_i;
    assign in_ready_o  = rdy[0];
    assign rdy[Cuts]   = out_ready_i;
    assign out_valid_o = vld[Cuts];
    assign out_data_o  = dat[Cuts];
    assign empty_o     = &emp;

    for (genvar i = 0; i < Cuts; i++) begin : g_stage
      axi_chan_multicut_stage #(
        .FullThru (FullThru),
        .data_t   (data_t)
      ) u_stage (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (vld[i]),
        .in_ready_o  (rdy[i]),
        .in_data_i   (dat[i]),
        .out_valid_o (vld[i+1]),
        .out_ready_i (rdy[i+1]),
        .out_data_o  (dat[i+1]),
        .empty_o     (emp[i])
      );
    end
  end
endmodule

module axi_chan_multicut #(
  parameter int unsigned AwCuts   = 1,
  parameter int unsigned WCuts    = 1,
  parameter int unsigned BCuts    = 1,
  parameter int unsigned ArCuts   = 1,
  parameter int unsigned RCuts    = 1,
  parameter bit          FullThru = 1'b1,
  parameter type aw_chan_t  = axi_chan_multicut_pkg::aw_chan_t,
  parameter type w_chan_t   = axi_chan_multicut_pkg::w_chan_t,
  parameter type b_chan_t   = axi_chan_multicut_pkg::b_chan_t,
  parameter type ar_chan_t  = axi_chan_multicut_pkg::ar_chan_t,
  parameter type r_chan_t   = axi_chan_multicut_pkg::r_chan_t,
  parameter type axi_req_t  = axi_chan_multicut_pkg::axi_req_t,
  parameter type axi_resp_t = axi_chan_multicut_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  output logic      idle_o
);
  logic aw_empty, w_empty, b_empty, ar_empty, r_empty;

  axi_chan_multicut_chan #(.Cuts(AwCuts), .FullThru(FullThru), .data_t(aw_chan_t)) u_aw (
    .clk_i, .rst_i,
    .in_valid_i  (slv_req_i.aw_valid),  .in_ready_o  (slv_resp_o.aw_ready),
    .in_data_i   (slv_req_i.aw),
    .out_valid_o (mst_req_o.aw_valid),  .out_ready_i (mst_resp_i.aw_ready),
    .out_data_o  (mst_req_o.aw),        .empty_o     (aw_empty)
  );

  axi_chan_multicut_chan #(.Cuts(WCuts), .FullThru(FullThru), .data_t(w_chan_t)) u_w (
    .clk_i, .rst_i,
    .in_valid_i  (slv_req_i.w_valid),   .in_ready_o  (slv_resp_o.w_ready),
    .in_data_i   (slv_req_i.w),
    .out_valid_o (mst_req_o.w_valid),   .out_ready_i (mst_resp_i.w_ready),
    .out_data_o  (mst_req_o.w),         .empty_o     (w_empty)
  );

  axi_chan_multicut_chan #(.Cuts(BCuts), .FullThru(FullThru), .data_t(b_chan_t)) u_b (
    .clk_i, .rst_i,
    .in_valid_i  (mst_resp_i.b_valid),  .in_ready_o  (mst_req_o.b_ready),
    .in_data_i   (mst_resp_i.b),
    .out_valid_o (slv_resp_o.b_valid),  .out_ready_i (slv_req_i.b_ready),
    .out_data_o  (slv_resp_o.b),        .empty_o     (b_empty)
  );

  axi_chan_multicut_chan #(.Cuts(ArCuts), .FullThru(FullThru), .data_t(ar_chan_t)) u_ar (
    .clk_i, .rst_i,
    .in_valid_i  (slv_req_i.ar_valid),  .in_ready_o  (slv_resp_o.ar_ready),
    .in_data_i   (slv_req_i.ar),
    .out_valid_o (mst_req_o.ar_valid),  .out_ready_i (mst_resp_i.ar_ready),
    .out_data_o  (mst_req_o.ar),        .empty_o     (ar_empty)
  );

  axi_chan_multicut_chan #(.Cuts(RCuts), .FullThru(FullThru), .data_t(r_chan_t)) u_r (
    .clk_i, .rst_i,
    .in_valid_i  (mst_resp_i.r_valid),  .in_ready_o  (mst_req_o.r_ready),
    .in_data_i   (mst_resp_i.r),
    .out_valid_o (slv_resp_o.r_valid),  .out_ready_i (slv_req_i.r_ready),
    .out_data_o  (slv_resp_o.r),        .empty_o     (r_empty)
  );

  assign idle_o = aw_empty & w_empty & b_empty & ar_empty & r_empty;
endmodule

// File: tb/tb_axi_chan_multicut.sv
// Directed bench: dut_a uses spill stages with mixed depths, dut_b uses half
// stages including a zero-cut AW channel.
module tb_axi_chan_multicut;
  import axi_chan_multicut_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  slv_req_a, mst_req_a, slv_req_b, mst_req_b;
  axi_resp_t slv_resp_a, mst_resp_a, slv_resp_b, mst_resp_b;
  logic      idle_a, idle_b;
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  axi_chan_multicut #(
    .AwCuts(1), .WCuts(2), .BCuts(1), .ArCuts(2), .RCuts(3), .FullThru(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .slv_req_i(slv_req_a), .slv_resp_o(slv_resp_a),
    .mst_req_o(mst_req_a), .mst_resp_i(mst_resp_a), .idle_o(idle_a)
  );

  axi_chan_multicut #(
    .AwCuts(0), .WCuts(4), .BCuts(1), .ArCuts(1), .RCuts(2), .FullThru(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .slv_req_i(slv_req_b), .slv_resp_o(slv_resp_b),
    .mst_req_o(mst_req_b), .mst_resp_i(mst_resp_b), .idle_o(idle_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic quiet();
    slv_req_a = '0; slv_req_b = '0; mst_resp_a = '0; mst_resp_b = '0;
    slv_req_a.b_ready = 1'b1; slv_req_a.r_ready = 1'b1;
    slv_req_b.b_ready = 1'b1; slv_req_b.r_ready = 1'b1;
    mst_resp_a.aw_ready = 1'b1; mst_resp_a.w_ready = 1'b1; mst_resp_a.ar_ready = 1'b1;
    mst_resp_b.aw_ready = 1'b1; mst_resp_b.w_ready = 1'b1; mst_resp_b.ar_ready = 1'b1;
  endtask

  initial begin
    int unsigned q[$];
    int unsigned sent, recv, acc, dlv, expd;
    logic wv;
    logic ev;

    // ---- reset with every valid asserted ----
    rst = 1'b1;
    quiet();
    slv_req_a.aw_valid = 1; slv_req_a.w_valid = 1; slv_req_a.ar_valid = 1;
    mst_resp_a.b_valid = 1; mst_resp_a.r_valid = 1;
    slv_req_b.aw_valid = 1; slv_req_b.w_valid = 1; slv_req_b.ar_valid = 1;
    mst_resp_b.b_valid = 1; mst_resp_b.r_valid = 1;
    repeat (2) cyc();
    smp();
    chk("rst_a_mst_aw_valid", mst_req_a.aw_valid, 0);
    chk("rst_a_mst_w_valid", mst_req_a.w_valid, 0);
    chk("rst_a_mst_ar_valid", mst_req_a.ar_valid, 0);
    chk("rst_a_slv_b_valid", slv_resp_a.b_valid, 0);
    chk("rst_a_slv_r_valid", slv_resp_a.r_valid, 0);
    chk("rst_a_slv_aw_ready", slv_resp_a.aw_ready, 1);
    chk("rst_a_slv_w_ready", slv_resp_a.w_ready, 1);
    chk("rst_a_slv_ar_ready", slv_resp_a.ar_ready, 1);
    chk("rst_a_mst_b_ready", mst_req_a.b_ready, 1);
    chk("rst_a_mst_r_ready", mst_req_a.r_ready, 1);
    chk("rst_a_idle", idle_a, 1);
    chk("rst_b_idle", idle_b, 1);
    chk("rst_b_aw_mirror_valid", mst_req_b.aw_valid, 1);
    chk("rst_b_aw_mirror_ready", slv_resp_b.aw_ready, 1);
    chk("rst_b_mst_w_valid", mst_req_b.w_valid, 0);

    // ---- first AW beat after release, AwCuts=1 ----
    cyc();
    rst = 1'b0;
    quiet();
    slv_req_a.aw_valid = 1; slv_req_a.aw.addr = 32'h100;
    smp();
    chk("aw_lat_pre_valid", mst_req_a.aw_valid, 0);
    chk("aw_lat_pre_ready", slv_resp_a.aw_ready, 1);
    cyc();
    slv_req_a.aw_valid = 0;
    smp();
    chk("aw_lat_valid", mst_req_a.aw_valid, 1);
    chk("aw_lat_addr", mst_req_a.aw.addr, 32'h100);
    chk("aw_lat_idle", idle_a, 0);
    cyc();
    smp();
    chk("aw_lat_drained", mst_req_a.aw_valid, 0);
    chk("aw_lat_idle_back", idle_a, 1);

    // ---- streaming 100 R beats through 3 spill stages ----
    for (int k = 0; k < 105; k++) begin
      cyc();
      mst_resp_a.r_valid = (k < 100);
      mst_resp_a.r.data  = k;
      smp();
      ev = (k >= 3 && k <= 102);
      chk("stream_r_valid", slv_resp_a.r_valid, ev);
      if (ev) chk("stream_r_data", slv_resp_a.r.data, k - 3);
      chk("stream_r_ready", mst_req_a.r_ready, 1);
      chk("stream_idle", idle_a, !(k >= 1 && k <= 102));
    end
    quiet();

    // ---- backpressure on W, WCuts=2, capacity 4 ----
    mst_resp_a.w_ready = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      slv_req_a.w_valid = 1; slv_req_a.w.data = 32'hA0 + k;
      smp();
      chk("bp_w_ready_open", slv_resp_a.w_ready, 1);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      slv_req_a.w_valid = 0;
      smp();
      chk("bp_w_ready_full", slv_resp_a.w_ready, 0);
      chk("bp_w_hold_valid", mst_req_a.w_valid, 1);
      chk("bp_w_hold_data", mst_req_a.w.data, 32'hA0);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      mst_resp_a.w_ready = 1;
      smp();
      chk("bp_w_drain_valid", mst_req_a.w_valid, k < 4);
      if (k < 4) chk("bp_w_drain_data", mst_req_a.w.data, 32'hA0 + k);
      chk("bp_w_ready_recover", slv_resp_a.w_ready, k >= 2);
    end
    quiet();

    // ---- half mode AR, ArCuts=1 on dut_b ----
    acc = 0; dlv = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      slv_req_b.ar_valid = 1; slv_req_b.ar.addr = acc;
      smp();
      chk("half_ar_ready", slv_resp_b.ar_ready, (k % 2) == 0);
      chk("half_ar_valid", mst_req_b.ar_valid, (k % 2) == 1);
      if (mst_req_b.ar_valid) begin
        chk("half_ar_addr", mst_req_b.ar.addr, dlv);
        dlv++;
      end
      if (slv_resp_b.ar_ready) acc++;
    end
    chk("half_ar_count", dlv, 10);
    cyc();
    mst_resp_b.ar_ready = 0; slv_req_b.ar.addr = acc;
    smp();
    chk("half_ar_stall_accept", slv_resp_b.ar_ready, 1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      slv_req_b.ar.addr = acc + 1;
      smp();
      chk("half_ar_stall_ready", slv_resp_b.ar_ready, 0);
      chk("half_ar_stall_valid", mst_req_b.ar_valid, 1);
      chk("half_ar_stall_addr", mst_req_b.ar.addr, 10);
    end
    cyc();
    slv_req_b.ar_valid = 0; mst_resp_b.ar_ready = 1;
    smp();
    chk("half_ar_release", mst_req_b.ar_valid, 1);
    cyc();
    smp();
    chk("half_ar_idle", idle_b, 1);
    quiet();

    // ---- mixed depths on dut_b: AW wire, W +4, B +1 ----
    cyc();
    slv_req_b.aw_valid = 1; slv_req_b.aw.addr = 32'h1234; mst_resp_b.aw_ready = 0;
    smp();
    chk("mix_aw_valid", mst_req_b.aw_valid, 1);
    chk("mix_aw_addr", mst_req_b.aw.addr, 32'h1234);
    chk("mix_aw_ready_lo", slv_resp_b.aw_ready, 0);
    chk("mix_aw_idle", idle_b, 1);
    mst_resp_b.aw_ready = 1;
    #1;
    chk("mix_aw_ready_hi", slv_resp_b.aw_ready, 1);
    cyc();
    quiet();
    slv_req_b.w_valid = 1; slv_req_b.w.data = 32'hAB;
    mst_resp_b.b_valid = 1; mst_resp_b.b.id = 4'h5;
    smp();
    chk("mix_b_pre", slv_resp_b.b_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      slv_req_b.w_valid = 0; mst_resp_b.b_valid = 0;
      smp();
      chk("mix_w_valid", mst_req_b.w_valid, k == 4);
      if (k == 4) chk("mix_w_data", mst_req_b.w.data, 32'hAB);
      chk("mix_b_valid", slv_resp_b.b_valid, k == 1);
      if (k == 1) chk("mix_b_id", slv_resp_b.b.id, 4'h5);
    end
    cyc();
    quiet();

    // ---- random valid/ready on dut_b W against a queue ----
    sent = 0; recv = 0; wv = 0;
    for (int k = 0; k < 230; k++) begin
      cyc();
      if (!wv && k < 200) wv = 1'($urandom_range(0, 1));
      slv_req_b.w_valid  = wv;
      slv_req_b.w.data   = sent;
      mst_resp_b.w_ready = (k >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
      smp();
      if (wv && slv_resp_b.w_ready) begin
        q.push_back(sent);
        sent++;
        wv = 0;
      end
      if (mst_req_b.w_valid && mst_resp_b.w_ready) begin
        expd = (q.size() != 0) ? q.pop_front() : 32'hDEADBEEF;
        chk("rand_w_data", mst_req_b.w.data, expd);
        recv++;
      end
    end
    chk("rand_w_left", q.size(), 0);
    chk("rand_w_count", recv, sent);
    quiet();

    // ---- reset with 3 R beats in flight on dut_a ----
    slv_req_a.r_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      slv_req_a.r_ready = 0;
      mst_resp_a.r_valid = 1; mst_resp_a.r.data = 32'h50 + k;
    end
    cyc();
    mst_resp_a.r_valid = 0;
    rst = 1'b1;
    smp();
    chk("midrst_busy", idle_a, 0);
    cyc();
    rst = 1'b0;
    slv_req_a.r_ready = 1;
    smp();
    chk("midrst_idle", idle_a, 1);
    for (int k = 0; k < 5; k++) begin
      chk("midrst_no_r", slv_resp_a.r_valid, 0);
      cyc();
      smp();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
